// File: rtl/spi_fram_model.sv
// Cycle-based behavioural model of an SPI FRAM (MB85RS-style command set).
// SPI pins are oversampled on clk; mode 0: mosi sampled on SCK rise,
// miso updated on SCK fall. Memory contents survive rst_n.
//
// state        | meaning
// S_OPCODE     | shifting in the 8-bit command
// S_ADDR       | shifting in ADDR_BYTES address bytes for READ/WRITE
// S_WRITE_DATA | receiving data bytes into memory
// S_READ_DATA  | streaming memory bytes out on miso
// S_RDSR       | streaming the status register repeatedly
// S_WRSR       | receiving the new status byte
// S_RDID       | streaming DEVICE_ID, then zeros
// S_IGNORE     | discarding everything until cs rises
module spi_fram_model #(
  parameter int          ADDR_BITS  = 13,
  parameter int          ADDR_BYTES = 2,
  parameter logic [31:0] DEVICE_ID  = 32'h047F0302
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cs,
  input  logic spi_sck,
  input  logic mosi,
  input  logic wp_n,
  output logic miso
);

  localparam int         DEPTH     = 1 << ADDR_BITS;
  localparam logic [4:0] ADDR_LAST = 5'(ADDR_BYTES * 8 - 1);

  localparam logic [7:0] OP_WRSR  = 8'h01;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_RDID  = 8'h9F;

  typedef enum logic [2:0] {
    S_OPCODE, S_ADDR, S_WRITE_DATA, S_READ_DATA,
    S_RDSR, S_WRSR, S_RDID, S_IGNORE
  } state_t;

  state_t state, state_next;

  logic [7:0]           mem [DEPTH];
  logic                 sck_q, cs_q;
  logic [6:0]           shift_in;
  logic [ADDR_BITS-2:0] addr_shift;
  logic [4:0]           bit_cnt;
  logic [7:0]           shift_out;
  logic [ADDR_BITS-1:0] addr;
  logic [7:0]           last_op;
  logic [2:0]           id_idx;
  logic                 wel, wpen;
  logic [1:0]           bp;

  logic                 sck_rise, sck_fall, cs_rise, byte_done;
  logic [7:0]           rx_byte, status, id_byte;
  logic [ADDR_BITS-1:0] rx_addr, addr_inc;
  logic [2:0]           id_next;
  logic                 addr_prot;

  // Shifting the address through an ADDR_BITS-wide register drops any
  // received bits above ADDR_BITS for free.
  assign sck_rise  = spi_sck & ~sck_q;
  assign sck_fall  = ~spi_sck & sck_q;
  assign cs_rise   = cs & ~cs_q;
  assign byte_done = sck_rise && (bit_cnt == 5'd7);
  assign rx_byte   = {shift_in, mosi};
  assign rx_addr   = {addr_shift, mosi};
  assign addr_inc  = addr + ADDR_BITS'(1);
  assign status    = {wpen, 3'b000, bp, wel, 1'b0};
  assign id_next   = (id_idx == 3'd4) ? 3'd4 : id_idx + 3'd1;

  // Next DEVICE_ID byte to stream, zeros once all four are sent.
  always_comb begin
    id_byte = 8'h00;
    case (id_next)
      3'd1:    id_byte = DEVICE_ID[23:16];
      3'd2:    id_byte = DEVICE_ID[15:8];
      3'd3:    id_byte = DEVICE_ID[7:0];
      default: id_byte = 8'h00;
    endcase
  end

  // Block-protection decode of the current write address.
  always_comb begin
    addr_prot = 1'b0;
    case (bp)
      2'b01:   addr_prot = &addr[ADDR_BITS-1 -: 2];
      2'b10:   addr_prot = addr[ADDR_BITS-1];
      2'b11:   addr_prot = 1'b1;
      default: addr_prot = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_OPCODE;
    else        state <= state_next;
  end

  // Next-state decode; cs high overrides any simultaneous SCK edge.
  always_comb begin
    state_next = state;
    if (cs) begin
      state_next = S_OPCODE;
    end else if (sck_rise) begin
      case (state)
        S_OPCODE:
          if (bit_cnt == 5'd7) begin
            case (rx_byte)
              OP_WREN, OP_WRDI:  state_next = S_OPCODE;
              OP_RDSR:           state_next = S_RDSR;
              OP_WRSR:           state_next = S_WRSR;
              OP_READ, OP_WRITE: state_next = S_ADDR;
              OP_RDID:           state_next = S_RDID;
              default:           state_next = S_IGNORE;
            endcase
          end
        S_ADDR:
          if (bit_cnt == ADDR_LAST) begin
            if (last_op == OP_READ) state_next = S_READ_DATA;
            else if (wel)           state_next = S_WRITE_DATA;
            else                    state_next = S_IGNORE;
          end
        S_WRSR:
          if (bit_cnt == 5'd7) state_next = S_IGNORE;
        default: state_next = state;
      endcase
    end
  end

  // Pin sampling, shift registers, counters, status and miso.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_q      <= 1'b0;
      cs_q       <= 1'b1;
      shift_in   <= '0;
      addr_shift <= '0;
      bit_cnt    <= '0;
      shift_out  <= '0;
      addr       <= '0;
      last_op    <= '0;
      id_idx     <= '0;
      wel        <= 1'b0;
      wpen       <= 1'b0;
      bp         <= 2'b00;
      miso       <= 1'b0;
    end else begin
      sck_q <= spi_sck;
      cs_q  <= cs;
      if (cs) begin
        shift_in   <= '0;
        addr_shift <= '0;
        bit_cnt    <= '0;
        shift_out  <= '0;
        id_idx     <= '0;
        miso       <= 1'b0;
        if (cs_rise) begin
          if (last_op == OP_WRITE || last_op == OP_WRSR) wel <= 1'b0;
          last_op <= '0;
        end
      end else if (sck_rise) begin
        shift_in <= rx_byte[6:0];
        bit_cnt  <= bit_cnt + 5'd1;
        case (state)
          S_OPCODE:
            if (bit_cnt == 5'd7) begin
              bit_cnt    <= '0;
              last_op    <= rx_byte;
              addr_shift <= '0;
              case (rx_byte)
                OP_WREN: wel <= 1'b1;
                OP_WRDI: wel <= 1'b0;
                OP_RDSR: shift_out <= status;
                OP_RDID: begin
                  shift_out <= DEVICE_ID[31:24];
                  id_idx    <= '0;
                end
                default: ;
              endcase
            end
          S_ADDR: begin
            addr_shift <= rx_addr[ADDR_BITS-2:0];
            if (bit_cnt == ADDR_LAST) begin
              bit_cnt   <= '0;
              addr      <= rx_addr;
              shift_out <= mem[rx_addr];
            end
          end
          S_READ_DATA:
            if (byte_done) begin
              bit_cnt   <= '0;
              addr      <= addr_inc;
              shift_out <= mem[addr_inc];
            end
          S_WRITE_DATA:
            if (byte_done) begin
              bit_cnt <= '0;
              addr    <= addr_inc;
            end
          S_RDSR:
            if (byte_done) begin
              bit_cnt   <= '0;
              shift_out <= status;
            end
          S_WRSR:
            if (byte_done) begin
              bit_cnt <= '0;
              if (wel && !(wpen && !wp_n)) begin
                wpen <= rx_byte[7];
                bp   <= rx_byte[3:2];
              end
            end
          S_RDID:
            if (byte_done) begin
              bit_cnt   <= '0;
              id_idx    <= id_next;
              shift_out <= id_byte;
            end
          default: bit_cnt <= '0;
        endcase
      end else if (sck_fall) begin
        if (state == S_READ_DATA || state == S_RDSR || state == S_RDID) begin
          miso      <= shift_out[7];
          shift_out <= {shift_out[6:0], 1'b0};
        end else begin
          miso <= 1'b0;
        end
      end
    end
  end

  // Memory array has no reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (rst_n && !cs && byte_done && state == S_WRITE_DATA && !addr_prot)
      mem[addr] <= rx_byte;
  end

endmodule

// File: tb/tb_spi_fram_model.sv
// Bench for spi_fram_model: SPI mode-0 driver with a byte scoreboard.
// Two instances: default geometry (a) and ADDR_BITS=10 (b).
module tb_spi_fram_model;

  logic clk = 1'b0;
  logic rst_n, cs_a, cs_b, spi_sck, mosi, wp_n;
  logic miso_a, miso_b;

  always #5 clk = ~clk;

  spi_fram_model dut_a (
    .clk(clk), .rst_n(rst_n), .cs(cs_a), .spi_sck(spi_sck),
    .mosi(mosi), .wp_n(wp_n), .miso(miso_a)
  );

  spi_fram_model #(.ADDR_BITS(10), .ADDR_BYTES(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .cs(cs_b), .spi_sck(spi_sck),
    .mosi(mosi), .wp_n(wp_n), .miso(miso_b)
  );

  logic [7:0] exp_q [$];
  string      name_q [$];
  logic [7:0] obs;
  logic       rx_valid = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;

  // Scoreboard monitor: compares each published byte with the oldest expectation.
  initial begin
    logic [7:0] e;
    string nm;
    forever begin
      @(posedge clk);
      if (rx_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_byte: got %02h with no expectation queued", obs);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          if (obs !== e) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h", nm, obs, e);
          end
        end
      end
    end
  end

  task automatic expect_byte(input logic [7:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic publish(input logic [7:0] o);
    @(negedge clk);
    obs      = o;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic xfer_bit(input logic b, input logic sel, output logic r);
    @(negedge clk);
    mosi = b;
    repeat (3) @(negedge clk);
    r = sel ? miso_b : miso_a;
    spi_sck = 1'b1;
    repeat (4) @(negedge clk);
    spi_sck = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] tx, input logic sel, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) xfer_bit(tx[i], sel, rx[i]);
  endtask

  task automatic cs_low(input logic sel);
    @(negedge clk);
    if (sel) cs_b = 1'b0;
    else     cs_a = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (2) @(negedge clk);
    cs_a = 1'b1;
    cs_b = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic cmd(input logic sel, input logic [7:0] op);
    logic [7:0] r;
    cs_low(sel);
    xfer(op, sel, r);
    cs_high();
  endtask

  task automatic do_write(input logic sel, input logic [15:0] a, input int n,
                          input logic [7:0] d0, input logic [7:0] d1);
    logic [7:0] r;
    cs_low(sel);
    xfer(8'h02, sel, r);
    xfer(a[15:8], sel, r);
    xfer(a[7:0], sel, r);
    xfer(d0, sel, r);
    if (n > 1) xfer(d1, sel, r);
    cs_high();
  endtask

  task automatic do_read(input logic sel, input logic [15:0] a, input int n,
                         input logic [7:0] e0, input logic [7:0] e1, input string nm);
    logic [7:0] r;
    cs_low(sel);
    xfer(8'h03, sel, r);
    xfer(a[15:8], sel, r);
    xfer(a[7:0], sel, r);
    for (int i = 0; i < n; i++) begin
      expect_byte((i == 0) ? e0 : e1, $sformatf("%s[%0d]", nm, i));
      xfer(8'h00, sel, r);
      publish(r);
    end
    cs_high();
  endtask

  task automatic wrsr(input logic [7:0] v);
    logic [7:0] r;
    cs_low(1'b0);
    xfer(8'h01, 1'b0, r);
    xfer(v, 1'b0, r);
    cs_high();
  endtask

  task automatic rdsr(input int n, input logic [7:0] e, input string nm);
    logic [7:0] r;
    cs_low(1'b0);
    xfer(8'h05, 1'b0, r);
    for (int i = 0; i < n; i++) begin
      expect_byte(e, $sformatf("%s[%0d]", nm, i));
      xfer(8'h00, 1'b0, r);
      publish(r);
    end
    cs_high();
  endtask

  // Watchdog so a stuck run still ends with a visible failure.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, compared %0d mismatched %0d", n_cmp, n_bad);
    $fatal(1);
  end

  // Directed stimulus.
  initial begin
    logic [7:0] r;
    logic       b;
    logic [7:0] id_exp [6];
    logic [7:0] part;
    id_exp = '{8'h04, 8'h7F, 8'h03, 8'h02, 8'h00, 8'h00};

    rst_n = 1'b0; cs_a = 1'b1; cs_b = 1'b1; spi_sck = 1'b0; mosi = 1'b0; wp_n = 1'b1;
    repeat (5) @(negedge clk);
    expect_byte(8'h00, "reset_miso_a");
    publish({7'd0, miso_a});
    expect_byte(8'h00, "reset_miso_b");
    publish({7'd0, miso_b});
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Status after reset, WREN / WRDI
    rdsr(1, 8'h00, "rdsr_reset");
    cmd(1'b0, 8'h06);
    rdsr(1, 8'h02, "rdsr_wel_set");
    cmd(1'b0, 8'h04);
    rdsr(1, 8'h00, "rdsr_wrdi");

    // Basic write / read, WEL cleared by end of WRITE
    cmd(1'b0, 8'h06);
    do_write(1'b0, 16'h0010, 2, 8'hA5, 8'h3C);
    do_read(1'b0, 16'h0010, 2, 8'hA5, 8'h3C, "read_0010");
    rdsr(1, 8'h00, "wel_cleared_after_write");

    // WRITE without WREN leaves memory unchanged
    cmd(1'b0, 8'h06);
    do_write(1'b0, 16'h0020, 1, 8'h11, 8'h00);
    do_write(1'b0, 16'h0020, 1, 8'h77, 8'h00);
    do_read(1'b0, 16'h0020, 1, 8'h11, 8'h00, "write_no_wren");

    // Block protection
    cmd(1'b0, 8'h06); do_write(1'b0, 16'h0000, 1, 8'h5A, 8'h00);
    cmd(1'b0, 8'h06); do_write(1'b0, 16'h1800, 1, 8'h66, 8'h00);
    cmd(1'b0, 8'h06); do_write(1'b0, 16'h17FF, 1, 8'h55, 8'h00);
    cmd(1'b0, 8'h06); wrsr(8'h0C);
    rdsr(1, 8'h0C, "rdsr_bp11");
    cmd(1'b0, 8'h06); do_write(1'b0, 16'h0000, 1, 8'hFF, 8'h00);
    do_read(1'b0, 16'h0000, 1, 8'h5A, 8'h00, "bp11_protected");
    cmd(1'b0, 8'h06); wrsr(8'h04);
    rdsr(1, 8'h04, "rdsr_bp01");
    cmd(1'b0, 8'h06); do_write(1'b0, 16'h17FF, 2, 8'hAA, 8'hBB);
    do_read(1'b0, 16'h17FF, 2, 8'hAA, 8'h66, "bp01_boundary");

    // WP pin and WPEN
    wp_n = 1'b0;
    cmd(1'b0, 8'h06); wrsr(8'h00);
    rdsr(1, 8'h00, "wrsr_wp_low_wpen0");
    wp_n = 1'b1;
    cmd(1'b0, 8'h06); wrsr(8'h80);
    rdsr(1, 8'h80, "wrsr_wpen_set");
    wp_n = 1'b0;
    cmd(1'b0, 8'h06); wrsr(8'h8C);
    rdsr(1, 8'h80, "wrsr_blocked_by_wp");
    wp_n = 1'b1;
    cmd(1'b0, 8'h06); wrsr(8'h00);
    rdsr(1, 8'h00, "wrsr_clear");

    // Address wrap and ignored upper address bits
    cmd(1'b0, 8'h06); do_write(1'b0, 16'h1FFF, 2, 8'hC3, 8'hD4);
    do_read(1'b0, 16'h1FFF, 2, 8'hC3, 8'hD4, "wrap_13b");
    do_read(1'b0, 16'hFFFF, 1, 8'hC3, 8'h00, "upper_bits_13b");

    // ADDR_BITS=10 instance
    cmd(1'b1, 8'h06); do_write(1'b1, 16'h03FF, 2, 8'hE1, 8'hE2);
    do_read(1'b1, 16'hFC00, 1, 8'hE2, 8'h00, "upper_bits_10b");
    do_read(1'b1, 16'h07FF, 2, 8'hE1, 8'hE2, "wrap_10b");

    // RDID
    cs_low(1'b0);
    xfer(8'h9F, 1'b0, r);
    for (int i = 0; i < 6; i++) begin
      expect_byte(id_exp[i], $sformatf("rdid[%0d]", i));
      xfer(8'h00, 1'b0, r);
      publish(r);
    end
    cs_high();

    // Unknown opcode, then a working command with streamed status
    cmd(1'b0, 8'h06);
    cs_low(1'b0);
    xfer(8'hAB, 1'b0, r);
    for (int i = 0; i < 2; i++) begin
      expect_byte(8'h00, $sformatf("ignore_op_ab[%0d]", i));
      xfer(8'h00, 1'b0, r);
      publish(r);
    end
    cs_high();
    rdsr(2, 8'h02, "rdsr_stream_after_ab");
    cmd(1'b0, 8'h04);

    // Reset in the middle of a write byte
    cmd(1'b0, 8'h06); do_write(1'b0, 16'h0030, 1, 8'h9A, 8'h00);
    cmd(1'b0, 8'h06); wrsr(8'h04);
    cmd(1'b0, 8'h06);
    part = 8'h12;
    cs_low(1'b0);
    xfer(8'h02, 1'b0, r);
    xfer(8'h00, 1'b0, r);
    xfer(8'h30, 1'b0, r);
    for (int i = 7; i >= 4; i--) xfer_bit(part[i], 1'b0, b);
    @(negedge clk); rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 3; i >= 0; i--) xfer_bit(part[i], 1'b0, b);
    cs_high();
    rdsr(1, 8'h00, "status_after_reset");
    do_read(1'b0, 16'h0030, 1, 8'h9A, 8'h00, "aborted_write");
    do_read(1'b0, 16'h0010, 2, 8'hA5, 8'h3C, "retained_0010");

    repeat (4) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_fram_model.md
Name: spi_fram_model

Overview:
- Parametrised cycle-based behavioural model of an SPI FRAM (MB85RS-family command set) for system-level benches of the SPI master.
- Oversamples the SPI pins on the system clock.
- Adds RDSR/WRSR/WRDI/RDID, block protection, a WP pin, configurable address width and depth, and true mode-0 timing: MISO changes on SCK falling edges.
- Sits on the bench side of the SoC SPI pins, in place of a discrete FRAM.

Parameters:
- ADDR_BITS, 13: effective memory address width. Depth is 2^ADDR_BITS bytes.
- ADDR_BYTES, 2: number of address bytes clocked after READ/WRITE (1..3). Received address bits above ADDR_BITS are ignored.
- DEVICE_ID, 32'h047F0302: RDID response, MSB byte first.

Ports:
- clk  in  1  system clock; all logic runs on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- cs  in  1  chip select, active low.
- spi_sck  in  1  SPI clock, mode 0; idle low.
- mosi  in  1  serial data in, MSB first.
- wp_n  in  1  write-protect pin, active low.
- miso  out  1  serial data out; driven 0 when idle. No tri-state.

Behaviour:
- Edge detection:
  - spi_sck and cs are registered once.
  - A rise or fall is detected when the current value differs from the registered one.
  - The action occurs on the clk following the edge.
  - SCK high and low phases must each last at least 2 clk cycles.
- Reset (rst_n low at a clk edge):
  - miso=0, state=OPCODE, all shift registers and bit counters =0.
  - Status register = 8'h00.
  - Memory contents are retained (not cleared).
  - Reset mid-transaction aborts it. No partial byte is written.
- cs high:
  - State returns to OPCODE, counters clear, miso=0.
  - A partially received data byte is discarded.
  - If the last opcode was WRITE or WRSR, WEL clears on the cs rise.
- Status register layout: [7]=WPEN, [3:2]=BP1:BP0, [1]=WEL. All other bits read 0.
- Mosi is sampled on SCK rising edges. Miso updates on SCK falling edges.
- States: OPCODE, ADDR, WRITE_DATA, READ_DATA, RDSR, WRSR, RDID, IGNORE.
- After the 8th opcode bit:
  - 06 WREN: sets WEL; stays in OPCODE.
  - 04 WRDI: clears WEL; stays in OPCODE.
  - 05 RDSR: goes to RDSR.
  - 01 WRSR: goes to WRSR.
  - 03 READ / 02 WRITE: goes to ADDR.
  - 9F RDID: goes to RDID.
  - Any other value: goes to IGNORE until cs rises.
- ADDR:
  - Receives ADDR_BYTES*8 bits. addr = low ADDR_BITS of the received value.
  - READ: goes to READ_DATA. Bit 7 of mem[addr] is driven on the falling edge that follows the last address bit.
  - WRITE with WEL=1: goes to WRITE_DATA. WRITE with WEL=0: goes to IGNORE.
- READ_DATA:
  - Shifts out MSB first.
  - After 8 bits, addr increments modulo 2^ADDR_BITS (wraps 2^ADDR_BITS-1 to 0), and the next byte is loaded.
  - Reading continues indefinitely.
- WRITE_DATA:
  - On each 8th bit, the byte is written to mem[addr] unless addr is protected. addr increments modulo depth either way.
  - Protected ranges: BP=01 protects the upper quarter, BP=10 the upper half, BP=11 all of memory, BP=00 none.
- WRSR:
  - After 8 bits, if WEL=1 and not (WPEN=1 and wp_n=0), load status bits 7, 3 and 2 from the byte.
  - Otherwise the byte is ignored. WEL is not written by WRSR.
  - Further bits are ignored.
- RDSR: streams the status register repeatedly. The first bit is driven on the falling edge after the opcode.
- RDID: streams the 4 bytes of DEVICE_ID, then 8'h00 for the rest of the transaction.
- Simultaneous events:
  - cs rise and SCK edge in the same clk: cs wins; the SCK edge is ignored.
  - rst_n overrides everything.

Test Plan:
- WREN; WRITE addr 16'h0010 with bytes A5,3C; then READ 16'h0010 for 2 bytes -> miso returns A5 then 3C, MSB first, each bit valid before the SCK rising edge.
- WRITE without a prior WREN -> memory unchanged. Full write with WREN, then cs rise -> RDSR reads 8'h00 (WEL cleared).
- WREN; WRSR 8'h0C (BP=11); WREN; WRITE 0x0000 with 8'hFF -> a read returns the old value. WRSR 8'h00 issued with wp_n=0 and WPEN=0 is accepted.
- READ starting at 2^ADDR_BITS-1 for 2 bytes -> second byte comes from address 0. Repeat with ADDR_BITS=10, ADDR_BYTES=2, checking that upper address bits are ignored.
- RDID -> 04,7F,03,02,00. Opcode 8'hAB -> miso stays 0 until cs rises, and the next command works.
- rst_n low midway through a WRITE byte -> byte not written, status 8'h00, earlier memory contents still readable.
